// File: rtl/i2s_audio_transmitter.sv
// I2S transmitter: 64 bit-clock frames, two 32-bit slots, MSB first, samples left-justified.
// Generates sck/ws from clk and accepts one stereo pair per frame via valid/ready.
module i2s_audio_transmitter #(
  parameter int clk_mhz         = 50,
  parameter int w_sample        = 16,
  parameter int sck_half_period = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [w_sample-1:0] left,
  input  logic [w_sample-1:0] right,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                underrun,
  output logic                sck,
  output logic                ws,
  output logic                sd
);

  localparam int DW = (sck_half_period > 1) ? $clog2(sck_half_period) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(sck_half_period - 1);

  if (clk_mhz < 1 || w_sample < 1 || w_sample > 32 || sck_half_period < 1) begin : g_param_check
    $error("i2s_audio_transmitter: parameter out of range");
  end

  logic [DW-1:0]       div_q, div_d;
  logic                sck_q, sck_d;
  logic [5:0]          slot_q, slot_d;
  logic                ws_q, ws_d;
  logic                sd_q, sd_d;
  logic [w_sample-1:0] left_q, left_d;
  logic [w_sample-1:0] right_q, right_d;
  logic [63:0]         sh_q, sh_d;

  logic                tick;
  logic                fall;
  logic                boundary;
  logic [63:0]         frame_w;

  always_comb begin
    tick     = (div_q == DIV_LAST);
    fall     = tick & sck_q;
    boundary = fall & (slot_q == 6'd63);

    div_d   = tick ? '0 : div_q + DW'(1);
    sck_d   = tick ? ~sck_q : sck_q;
    slot_d  = slot_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    sh_d    = sh_q;
    left_d  = left_q;
    right_d = right_q;

    if (boundary && sample_valid) begin
      left_d  = left;
      right_d = right;
    end

    // Bit (63 - s) of frame_w is the sd value for slot s; a 32-bit right LSB falls off the end.
    frame_w = (64'(left_d) << (63 - w_sample))
            | ((64'(right_d) << 31) >> w_sample);

    if (fall) begin
      slot_d = slot_q + 6'd1;
      ws_d   = slot_d[5];
      if (boundary) begin
        sd_d = frame_w[63];
        sh_d = {frame_w[62:0], 1'b0};
      end else begin
        sd_d = sh_q[63];
        sh_d = {sh_q[62:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      sck_q   <= 1'b0;
      slot_q  <= 6'd63;
      ws_q    <= 1'b1;
      sd_q    <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      sh_q    <= '0;
    end else begin
      div_q   <= div_d;
      sck_q   <= sck_d;
      slot_q  <= slot_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      left_q  <= left_d;
      right_q <= right_d;
      sh_q    <= sh_d;
    end
  end

  assign sample_ready = boundary;
  assign underrun     = boundary & ~sample_valid;
  assign sck          = sck_q;
  assign ws           = ws_q;
  assign sd           = sd_q;

endmodule
